fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the instruction buffer entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of the outstanding request, word-aligned.
REQ-007 imem_ack  input  1  memory response strobe; imem_rdata is valid in that cycle.
REQ-008 imem_rdata  input  32  instruction word returned by memory.
REQ-009 redirect  input  1  taken branch/jump from the datapath; flush and restart.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-011 inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 inst_out  output  32  instruction at the buffer head.
REQ-013 inst_pc  output  32  address of inst_out.
REQ-014 inst_ready  input  1  datapath consumes the head when inst_valid=1 and inst_ready=1.

Function
REQ-015 FSM states SHALL be IDLE, REQ and DROP; imem_req SHALL equal (state==REQ), and imem_addr SHALL equal fetch_pc.
REQ-016 The block SHALL go from IDLE to REQ when occupancy after this cycle's pop is below DEPTH and redirect=0.
REQ-017 In REQ with imem_ack=1 and redirect=0: the block SHALL push {imem_rdata, fetch_pc}, set fetch_pc += 4 (mod 2^32), stay in REQ if a slot remains after push/pop, and otherwise go to IDLE.
REQ-018 While imem_req=1 and imem_ack=0, imem_addr SHALL be held stable.
REQ-019 At most one memory request SHALL be outstanding; a slot is reserved before issue, so a push SHALL never overflow.
REQ-020 A pushed entry SHALL appear on inst_valid/inst_out/inst_pc in the next cycle (1-cycle latency); with zero-wait memory, throughput SHALL be 1 instruction/cycle.
REQ-021 Pop and push in the same cycle SHALL be allowed at any occupancy, including full and empty.
REQ-022 On redirect=1: the buffer SHALL be emptied and fetch_pc SHALL load {redirect_pc[31:2],2'b00} at the next edge, and inst_valid SHALL be 0 in the next cycle.
REQ-023 A redirect in REQ with imem_ack=0 SHALL go to DROP; in DROP, imem_req=0, the next imem_ack SHALL be discarded, and the FSM SHALL then go to IDLE.
REQ-024 A redirect in the same cycle as imem_ack SHALL discard that response and go to IDLE (not DROP).
REQ-025 A redirect in DROP SHALL update fetch_pc and remain in DROP.
REQ-026 A pop coinciding with redirect SHALL be honoured (the consumer took the head); all remaining entries are flushed.
REQ-027 An imem_ack received in IDLE SHALL be ignored.

Reset
REQ-028 While rst=1: state=IDLE, fetch_pc=RESET_PC, buffer empty, inst_valid=0, inst_out=0, inst_pc=0, imem_req=0, imem_addr=RESET_PC.
REQ-029 Assertion of rst mid-request SHALL abandon the request; the memory is reset by the same rst.
REQ-030 The first imem_req SHALL assert in the cycle after the first clock edge following rst deassertion.

Configuration
REQ-031 With macro FETCH_PERF_CNT_EN defined: 32-bit outputs perf_fetched (incremented per pop), perf_flushed (incremented by entries discarded on redirect, including a dropped or discarded response) and perf_stall (cycles with inst_ready=1 and inst_valid=0) SHALL exist, reset to 0, and wrap at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN: these ports and their counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 Reset with RESET_PC=0x100, imem_ack tied to 1, inst_ready=1 -> inst_pc SHALL be 0x100, 0x104, 0x108 on consecutive cycles, with inst_valid continuous from the 3rd cycle after reset.
REQ-034 inst_ready=0, 1-cycle ack, DEPTH=4 -> exactly 4 requests (0x0..0xC), then imem_req=0; one pop SHALL cause one new request at 0x10.
REQ-035 Ack delayed 3 cycles, redirect to 0x200 in cycle 1 of wait -> state DROP; the late data SHALL be discarded; the next request SHALL be at 0x200, and the first inst_pc SHALL be 0x200.
REQ-036 Redirect to 0x403 coincident with imem_ack -> response discarded, no DROP, next imem_addr=0x400.
REQ-037 With FETCH_PERF_CNT_EN, fill 3 entries, redirect -> perf_flushed=3, inst_valid=0 next cycle.
REQ-038 rst asserted mid-wait -> all outputs SHALL match REQ-028 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : instruction fetch FSM with a DEPTH-entry instruction buffer.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   buf_inst [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];

  logic        pop;
  logic        push;
  logic [AW:0] cnt_after_pop;
  logic [AW:0] cnt_next;
  logic [31:0] aligned_pc;
  logic        unused_pc_bits;

  assign inst_valid     = (count != '0);
  assign pop            = inst_valid & inst_ready;
  assign push           = (state == REQ) & imem_ack & ~redirect;
  assign cnt_after_pop  = count - {{AW{1'b0}}, pop};
  assign cnt_next       = cnt_after_pop + {{AW{1'b0}}, push};
  assign aligned_pc     = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;
  assign inst_out  = inst_valid ? buf_inst[rd_ptr] : 32'h0;
  assign inst_pc   = inst_valid ? buf_pc[rd_ptr]   : 32'h0;

  // Storage needs no reset: occupancy gates everything that is observed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= aligned_pc;
      case (state)
        REQ:     state <= imem_ack ? IDLE : DROP;
        // An ack arriving in DROP still retires the abandoned request, so
        // leaving DROP here cannot strand the FSM waiting for a second ack.
        DROP:    state <= imem_ack ? IDLE : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_next;
      case (state)
        IDLE: begin
          if (cnt_after_pop < FULL_CNT) state <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (cnt_next >= FULL_CNT) state <= IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        resp_dropped;
  logic [31:0] flush_inc;

  assign resp_dropped = imem_ack & ((state == DROP) | ((state == REQ) & redirect));
  assign flush_inc    = (redirect ? 32'(cnt_after_pop) : 32'h0) + 32'(resp_dropped);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_flushed <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= perf_flushed + flush_inc;
      if (inst_ready && !inst_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Scoreboard bench for fetch_unit (RESET_PC=0x100, DEPTH=4); perf checks
// are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_stall;
  logic [31:0] base;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h100), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed),
    .perf_stall  (perf_stall)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen mid-cycle is consumed at the next edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h want none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst_out, ~e);
      end
    end
  end

  // Memory model: one request at a time, answers after lat wait cycles.
  bit          mem_en;
  int          lat;
  bit          pending;
  int          wcnt;
  logic [31:0] paddr;
  logic [31:0] ack_log[$];

  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
      if (mem_en) imem_ack = 1'b0;
    end else if (mem_en) begin
      if (!pending && imem_req) begin
        pending = 1'b1;
        paddr   = imem_addr;
        wcnt    = 0;
      end
      if (pending && wcnt == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = ~paddr;
        pending    = 1'b0;
        ack_log.push_back(paddr);
      end else begin
        imem_ack = 1'b0;
        if (pending) wcnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'h0, imem_req},   32'h0);
    chk({tag, "_addr"},  imem_addr,           32'h100);
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
    chk({tag, "_out"},   inst_out,            32'h0);
    chk({tag, "_pc"},    inst_pc,             32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_perf_f"}, perf_fetched, 32'h0);
    chk({tag, "_perf_x"}, perf_flushed, 32'h0);
    chk({tag, "_perf_s"}, perf_stall,   32'h0);
`endif
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; mem_en = 1'b1; lat = 0;

    // Reset state, then zero-wait streaming from RESET_PC
    repeat (2) cyc();
    chk_reset_outputs("rst");
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C); exp_q.push_back(32'h110);
    rst = 1'b0;
    chk("pre_req", {31'h0, imem_req}, 32'h0);
    cyc();
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_valid", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("stream_valid", {31'h0, inst_valid}, 32'h1);
    end
    inst_ready = 1'b0;
    repeat (6) cyc();

    // Fill with consumer stalled: exactly four requests, then one refill
    lat = 1;
    redirect = 1'b1; redirect_pc = 32'h0;
    cyc();
    redirect = 1'b0;
    chk("flush_valid", {31'h0, inst_valid}, 32'h0);
    ack_log.delete();
    repeat (20) cyc();
    chk("fill_count", ack_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("fill_addr", ack_log[i], 32'(i * 4));
    chk("fill_req_off", {31'h0, imem_req}, 32'h0);
    chk("fill_head", inst_pc, 32'h0);
    exp_q.push_back(32'h0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("refill_req", {31'h0, imem_req}, 32'h1);
    chk("refill_addr", imem_addr, 32'h10);
    repeat (4) cyc();
    chk("refill_count", ack_log.size(), 32'd5);
    chk("refill_ack_addr", ack_log[4], 32'h10);
    chk("refill_req_off", {31'h0, imem_req}, 32'h0);

    // Redirect while waiting on a slow ack -> DROP, late data discarded
    mem_en = 1'b0; imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("wait_addr", imem_addr, 32'h300);
    cyc();
    chk("hold_addr", imem_addr, 32'h300);
    chk("hold_req", {31'h0, imem_req}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    chk("drop_req", {31'h0, imem_req}, 32'h0);
    chk("drop_valid", {31'h0, inst_valid}, 32'h0);
    cyc();
    chk("drop_hold", {31'h0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ack = 1'b0;
    chk("late_discard", {31'h0, inst_valid}, 32'h0);
    cyc();
    chk("drop_next_req", {31'h0, imem_req}, 32'h1);
    chk("drop_next_addr", imem_addr, 32'h200);
    imem_ack = 1'b1; imem_rdata = ~32'h200;
    cyc();
    imem_ack = 1'b0;
    chk("drop_first_pc", inst_pc, 32'h200);
    chk("drop_first_inst", inst_out, ~32'h200);

    // Redirect coincident with ack: no DROP, misaligned target aligned
    redirect = 1'b1; redirect_pc = 32'h403; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    redirect = 1'b0; imem_ack = 1'b0;
    chk("coinc_valid", {31'h0, inst_valid}, 32'h0);
    cyc();
    chk("coinc_req", {31'h0, imem_req}, 32'h1);
    chk("coinc_addr", imem_addr, 32'h400);

    // Three entries then redirect while a request is outstanding
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = ~imem_addr;
      cyc();
    end
    imem_ack = 1'b0;
    chk("three_head", inst_pc, 32'h400);
    chk("three_addr", imem_addr, 32'h40C);
`ifdef FETCH_PERF_CNT_EN
    base = perf_flushed;
`endif
    redirect = 1'b1; redirect_pc = 32'h500;
    cyc();
    redirect = 1'b0;
    chk("three_flush_valid", {31'h0, inst_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_flushed3", perf_flushed - base, 32'd3);
`endif
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_flushed4", perf_flushed - base, 32'd4);
`endif
    cyc();
    chk("after_drop_addr", imem_addr, 32'h500);

    // Pop coinciding with redirect is honoured
    imem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      imem_rdata = ~imem_addr;
      cyc();
    end
    imem_ack = 1'b0;
    exp_q.push_back(32'h500);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h600;
    cyc();
    inst_ready = 1'b0; redirect = 1'b0;
    chk("popredir_valid", {31'h0, inst_valid}, 32'h0);
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    cyc();
    chk("popredir_addr", imem_addr, 32'h600);

    // Asynchronous reset in the middle of a wait
    imem_ack = 1'b1; imem_rdata = ~imem_addr;
    cyc();
    imem_ack = 1'b0;
    chk("prerst_valid", {31'h0, inst_valid}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    mem_en = 1'b1; lat = 0; inst_ready = 1'b1;
    cyc();
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    rst = 1'b0;
    cyc();
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    repeat (4) cyc();
    inst_ready = 1'b0;
    repeat (6) cyc();
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
